// File: rtl/keyframe_scheduler_pkg.sv
// Shared definitions for the keyframe scheduler: bank indices, FSM states and
// field-width defaults common with the SPI keyframe receiver.
package keyframe_scheduler_pkg;

    localparam int c_time_w_default = 10;
    localparam int c_type_w_default = 6;

    localparam logic [1:0] BANK_0 = 2'd0;
    localparam logic [1:0] BANK_1 = 2'd1;
    localparam logic [1:0] BANK_2 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRANS = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/keyframe_scheduler_channel_sweeper.sv
// Channel read sweeper: one start pulse produces exactly c_channels back-to-back
// read strobes with addresses 0..c_channels-1; done marks the last one.
module channel_sweeper #(
    parameter int c_channels = 32,
    parameter int c_addr_w   = $clog2(c_channels)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [c_addr_w-1:0] rd_addr
);

    localparam logic [c_addr_w-1:0] c_last = c_addr_w'(c_channels - 1);

    logic at_last;

    assign at_last = (rd_addr == c_last);
    assign done    = busy && at_last;
    assign rd_en   = busy;

    // NOTE: sequential state is assigned with <= only, so every register samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy    <= 1'b0;
            rd_addr <= '0;
        end else if (busy) begin
            if (at_last) begin
                busy    <= 1'b0;
                rd_addr <= '0;
            end else begin
                rd_addr <= rd_addr + 1'b1;
            end
        end else if (start) begin
            busy    <= 1'b1;
            rd_addr <= '0;
        end
    end

endmodule

// File: rtl/keyframe_scheduler.sv
// Keyframe scheduler: commits received keyframes into a rotating triple buffer,
// runs the timed transition FSM and issues per-tick channel read sweeps.
module keyframe_scheduler
    import keyframe_scheduler_pkg::*;
#(
    parameter int c_ledboards = 30,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_addr_w    = $clog2(c_channels),
    parameter int c_time_w    = c_time_w_default,
    parameter int c_type_w    = c_type_w_default
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cs,
    input  logic                i_wen,
    input  logic [c_time_w-1:0] i_time,
    input  logic [c_type_w-1:0] i_type,
    input  logic                i_tick,
    output logic                o_wr_en,
    output logic [1:0]          o_wr_bank,
    output logic [1:0]          o_from_bank,
    output logic [1:0]          o_to_bank,
    output logic                o_rd_en,
    output logic [c_addr_w-1:0] o_rd_addr,
    output logic [c_time_w-1:0] o_elapsed,
    output logic [c_time_w-1:0] o_duration,
    output logic [c_type_w-1:0] o_type,
    output logic                o_busy,
    output logic                o_overrun
);

    state_t              state;
    state_t              state_next;
    logic                r_prev_cs;
    logic                dirty;
    logic                pending;
    logic                tick_pending;
    logic                r_start;
    logic                r_relaunch;
    logic [1:0]          from_bank;
    logic [1:0]          to_bank;
    logic [1:0]          load_bank;
    logic [c_time_w-1:0] staged_time;
    logic [c_type_w-1:0] staged_type;
    logic [c_time_w-1:0] elapsed;
    logic [c_time_w-1:0] duration;
    logic [c_type_w-1:0] cur_type;
    logic                overrun;

    logic commit;
    logic at_end;
    logic sweep_start;
    logic sweep_busy;
    logic sweep_done;
    logic sweep_active;
    logic start_req;
    logic tick_launch;
    logic done_advance;
    logic tick_defer;
    logic tick_drop;

    assign commit = !r_prev_cs && i_cs && dirty;
    assign at_end = (elapsed == duration);

    // A sweep is "active" from the cycle it is requested, so a tick arriving
    // while a launch is in flight is deferred rather than launching twice.
    assign sweep_active = sweep_busy || r_start || r_relaunch;
    assign sweep_start  = r_start || r_relaunch || tick_launch;

    channel_sweeper #(
        .c_channels (c_channels),
        .c_addr_w   (c_addr_w)
    ) u_sweeper (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .start   (sweep_start),
        .busy    (sweep_busy),
        .done    (sweep_done),
        .rd_en   (o_rd_en),
        .rd_addr (o_rd_addr)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_next   = state;
        start_req    = 1'b0;
        tick_launch  = 1'b0;
        done_advance = 1'b0;
        tick_defer   = 1'b0;
        tick_drop    = 1'b0;
        unique case (state)
            S_IDLE, S_HOLD: begin
                if (r_start) begin
                    state_next = S_TRANS;
                end else if (pending && !sweep_active) begin
                    start_req = 1'b1;
                end
            end
            S_TRANS: begin
                if (sweep_done) begin
                    if (at_end) begin
                        state_next = S_HOLD;
                    end else if (tick_pending || i_tick) begin
                        done_advance = 1'b1;
                    end
                end else if (sweep_active) begin
                    if (i_tick) begin
                        if (tick_pending) tick_drop = 1'b1;
                        else              tick_defer = 1'b1;
                    end
                end else if (i_tick && !at_end) begin
                    tick_launch = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            r_prev_cs   <= 1'b1;
            dirty       <= 1'b0;
            pending     <= 1'b0;
            tick_pending <= 1'b0;
            r_start     <= 1'b0;
            r_relaunch  <= 1'b0;
            from_bank   <= BANK_0;
            to_bank     <= BANK_1;
            load_bank   <= BANK_2;
            staged_time <= '0;
            staged_type <= '0;
            elapsed     <= '0;
            duration    <= '0;
            cur_type    <= '0;
            overrun     <= 1'b0;
        end else begin
            state      <= state_next;
            r_prev_cs  <= i_cs;
            r_start    <= start_req;
            r_relaunch <= done_advance;
            dirty      <= i_wen || (dirty && !commit);

            // A commit in the rotation cycle belongs to the next frame and must survive.
            if (commit) begin
                pending     <= 1'b1;
                staged_time <= i_time;
                staged_type <= i_type;
            end else if (i_wen || r_start) begin
                pending <= 1'b0;
            end

            if (r_start) begin
                from_bank <= to_bank;
                to_bank   <= load_bank;
                load_bank <= from_bank;
                duration  <= (state == S_IDLE) ? '0 : staged_time;
                cur_type  <= staged_type;
                elapsed   <= '0;
            end else if (tick_launch || done_advance) begin
                elapsed <= elapsed + 1'b1;
            end

            if (state == S_TRANS && sweep_done) begin
                tick_pending <= !at_end && tick_pending && i_tick;
            end else if (tick_defer) begin
                tick_pending <= 1'b1;
            end

            if (tick_drop) overrun <= 1'b1;
        end
    end

    assign o_wr_en     = i_wen;
    assign o_wr_bank   = load_bank;
    assign o_from_bank = from_bank;
    assign o_to_bank   = to_bank;
    assign o_elapsed   = elapsed;
    assign o_duration  = duration;
    assign o_type      = cur_type;
    assign o_busy      = (state == S_TRANS);
    assign o_overrun   = overrun;

endmodule
